// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Optional feature macro: MULTIPLICADOR_EARLY_EXIT_EN (see multiplicador_seq).
package multiplicador_pkg;

  localparam int TAM_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } estado_t;

  // Two's-complement magnitude of the low w bits of v (w <= 64).
  // -2^(w-1) maps to 2^(w-1), which still fits w bits unsigned.
  function automatic logic [63:0] abs_tam(input logic [63:0] v, input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (v[6'(w - 1)]) return (~v + 64'd1) & mask;
    else              return v & mask;
  endfunction

endpackage

// File: rtl/multiplicador_passo.sv
// One combinational shift-add step: adds the multiplicand, shifted to the
// weight of the current multiplier bit, when that bit is set.
module multiplicador_passo
  import multiplicador_pkg::*;
#(
  parameter  int TAM   = TAM_DEFAULT,
  localparam int CNT_W = $clog2(TAM + 1)
) (
  input  logic [2*TAM-1:0] acc,
  input  logic [TAM-1:0]   mcand,
  input  logic             bit_mplier,
  input  logic [CNT_W-1:0] desloc,
  output logic [2*TAM-1:0] acc_next
);

  logic [2*TAM-1:0] parcial;

  // Partial product aligned to the bit weight, conditionally accumulated.
  always_comb begin
    parcial  = {{TAM{1'b0}}, mcand} << desloc;
    acc_next = bit_mplier ? (acc + parcial) : acc;
  end

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential radix-2 shift-add multiplier with valid/ready handshakes and
// per-operation signed/unsigned mode. Signed operands are multiplied as
// magnitudes and the sign is applied once on completion.
// Optional macro MULTIPLICADOR_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier is zero instead of always taking TAM steps.
module multiplicador_seq
  import multiplicador_pkg::*;
#(
  parameter  int TAM   = TAM_DEFAULT,
  localparam int CNT_W = $clog2(TAM + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAM-1:0]   A,
  input  logic [TAM-1:0]   B,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*TAM-1:0] S
);

  estado_t          state_q, state_d;
  logic [2*TAM-1:0] acc_q, acc_d;
  logic [TAM-1:0]   mcand_q, mcand_d;
  logic [TAM-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [2*TAM-1:0] s_q, s_d;

  logic [2*TAM-1:0] acc_next;
  logic [TAM-1:0]   mplier_shift;
  logic [CNT_W-1:0] cnt_dec;
  logic [CNT_W-1:0] desloc;
  logic             fim;

  // Step k (k = 0..TAM-1) weights the multiplicand by 2^k.
  assign desloc       = CNT_W'(TAM) - cnt_q;
  assign mplier_shift = mplier_q >> 1;
  assign cnt_dec      = cnt_q - CNT_W'(1);

  multiplicador_passo #(.TAM(TAM)) u_passo (
    .acc        (acc_q),
    .mcand      (mcand_q),
    .bit_mplier (mplier_q[0]),
    .desloc     (desloc),
    .acc_next   (acc_next)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      s_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      s_q      <= s_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    s_d      = s_q;
`ifdef MULTIPLICADOR_EARLY_EXIT_EN
    fim = (cnt_dec == '0) || (mplier_shift == '0);
`else
    fim = (cnt_dec == '0);
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = sgn ? TAM'(abs_tam(64'(A), TAM)) : A;
          mplier_d = sgn ? TAM'(abs_tam(64'(B), TAM)) : B;
          neg_d    = sgn & (A[TAM-1] ^ B[TAM-1]);
          acc_d    = '0;
          cnt_d    = CNT_W'(TAM);
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_next;
        mplier_d = mplier_shift;
        cnt_d    = cnt_dec;
        if (fim) begin
          s_d     = neg_q ? (~acc_next + 1'b1) : acc_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; product comes straight from a flop.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    S         = s_q;
  end

endmodule
